fetch_queue_unit: RTL
=====================

Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch stage that replaces the fixed PC/adder/next-PC mux front end of the 5-stage pipeline. It owns the PC, drives the combinational-read instruction memory, and buffers fetched {instruction, PC+4} pairs in a DEPTH-entry queue. The queue feeds decode through a valid/ready handshake. Redirects from later stages flush the queue, and an optional predecoder resolves J-type jumps in fetch.

Parameters:
XLEN, 32, datapath and PC width
IMEM_AW, 8, byte-address width presented to instruction memory
DEPTH, 4, queue entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset
PREDECODE_JUMP, 0, when 1, opcode 6'b000010 is redirected in fetch (requires XLEN=32)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch enable to instruction memory
imem_addr  out  IMEM_AW  byte address, equal to pc[IMEM_AW-1:0]
imem_rdata  in  XLEN  instruction, combinational same-cycle read
redirect_valid  in  1  branch/jump resolved taken downstream
redirect_pc  in  XLEN  redirect target
id_ready  in  1  decode accepts head entry this cycle
id_valid  out  1  head entry valid
id_instr  out  XLEN  head instruction
id_pc4  out  XLEN  head PC+4
fetch_pc  out  XLEN  current PC register (debug)
q_count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high on rst.
- While rst is high: pc=RESET_PC, count=0, pointers=0, imem_req=0, id_valid=0, id_instr=0, id_pc4=0.
- Reset asserted mid-operation clears all state immediately and discards in-flight data.
- deq = id_valid & id_ready & ~redirect_valid.
- enq = ~redirect_valid & (count<DEPTH | deq).
- imem_req = enq.
- Full queue with simultaneous dequeue still enqueues; count holds.
- On enq at the rising edge:
  - Write {imem_rdata, pc+4} at wr_ptr.
  - wr_ptr advances modulo DEPTH.
  - Next PC is pc+4 (modulo 2^XLEN, so 0xFFFFFFFC wraps to 0).
  - With PREDECODE_JUMP=1 and imem_rdata[31:26]==6'b000010, next PC is {pc4[31:28], imem_rdata[25:0], 2'b00}.
- In PREDECODE_JUMP=1 mode the jump instruction itself is still enqueued, and downstream must not redirect for j.
- No enq: PC holds.
- On deq: rd_ptr advances and count decrements. Simultaneous enq and deq leaves count unchanged.
- Latency:
  - An instruction fetched at edge N is visible at id_valid after edge N. There is no combinational bypass from imem_rdata to id_*.
  - First id_valid appears one cycle after rst deasserts.
- Redirect has highest priority:
  - Effect at the next edge: count=0, pointers=0, pc={redirect_pc[XLEN-1:2], 2'b00}.
  - In the redirect cycle: no enq, no deq, and id_valid is forced to 0 (combinational mask).
  - Redirect while empty, full, or dequeuing behaves identically.
- id_instr and id_pc4 are driven to 0 when count==0.
- q_count reflects registered occupancy.
- imem_addr is truncated to IMEM_AW bits, so addresses alias above 2^IMEM_AW.

Decomposition:
- Package fetch_pkg holds:
  - OPC_J = 6'b000010
  - INSTR_ALIGN = 2
  - A packed typedef fq_entry_t {instr, pc4}, parameterised by XLEN via the package localparam.
- Sub-module fetch_fifo:
  - Synchronous DEPTH x entry storage with rd/wr pointers, count, flush input, and async reset.
  - It holds the queue only. fetch_queue_unit keeps the PC, next-PC selection, predecode, and redirect priority.

Test Plan:
1. Reset release, id_ready=1, memory returns instr = 0xA000_0000|addr -> consecutive cycles present (instr 0xA0000000, pc4 4), (0xA0000004, 8), (0xA0000008, 12); q_count stays 1.
2. id_ready=0 for 6 cycles -> q_count reaches 4 holding pc4 4,8,12,16; imem_req=0 and fetch_pc=16 while held. Then set id_ready=1 -> entries drain in order with no gaps or duplicates.
3. Queue holds 3 entries, redirect_valid=1 with redirect_pc=0x43 -> id_valid=0 that cycle; next cycle q_count=0 and fetch_pc=0x40; following cycle head pc4=0x44.
4. Full queue, id_ready=1, redirect_valid=1 in the same cycle -> no dequeue is counted and the queue is flushed; redirect wins. Separately, fetch_pc=0xFFFFFFFC -> next fetch_pc=0.
5. PREDECODE_JUMP=1, memory word at 0x8 is 0x08000008 -> the jump is enqueued with pc4 0xC; the next enqueued entry has pc4 0x24 (fetched from 0x20).
6. Assert rst asynchronously mid-cycle with q_count=3 -> id_valid, q_count and imem_req go 0 immediately and fetch_pc=RESET_PC before the next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// A queue entry pairs a fetched instruction with its PC+4 link value.
package fetch_pkg;

    localparam int         FQ_XLEN     = 32;
    localparam logic [5:0] OPC_J       = 6'b000010;
    localparam int         INSTR_ALIGN = 2;

    typedef struct packed {
        logic [FQ_XLEN-1:0] instr;
        logic [FQ_XLEN-1:0] pc4;
    } fq_entry_t;

    // J-type target: upper nibble of PC+4 concatenated with the word index.
    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [31:0] instr);
        return {pc4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched entries between fetch and decode.
// Flush discards all contents in one cycle; pointers restart at zero.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  fq_entry_t                  wdata,
    output fq_entry_t                  rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fq_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; stale slots are never exposed while count is zero.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and
// buffers {instr, pc+4} pairs for decode behind a valid/ready handshake.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN           = FQ_XLEN,
    parameter int               IMEM_AW        = 8,
    parameter int               DEPTH          = 4,
    parameter logic [XLEN-1:0]  RESET_PC       = '0,
    parameter bit               PREDECODE_JUMP = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [IMEM_AW-1:0]         imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic                       id_ready,
    output logic                       id_valid,
    output logic [XLEN-1:0]            id_instr,
    output logic [XLEN-1:0]            id_pc4,
    output logic [XLEN-1:0]            fetch_pc,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int              CW         = $clog2(DEPTH+1);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((1 << INSTR_ALIGN) - 1);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] pc_next;
    logic [CW-1:0]   count;
    logic            head_valid;
    logic            deq;
    logic            enq;
    logic            is_jump;
    fq_entry_t       wr_entry;
    fq_entry_t       head;

    assign pc4        = pc + XLEN'(4);
    assign head_valid = (count != '0);

    // Redirect masks the head so decode never sees wrong-path work.
    assign id_valid = head_valid & ~redirect_valid;
    assign deq      = id_valid & id_ready;
    assign enq      = ~redirect_valid & ((count < CW'(DEPTH)) | deq);
    assign imem_req = enq & ~rst;

    assign imem_addr = pc[IMEM_AW-1:0];
    assign is_jump   = PREDECODE_JUMP && (imem_rdata[31:26] == OPC_J);

    assign wr_entry.instr = imem_rdata;
    assign wr_entry.pc4   = pc4;

    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_pc & ~ALIGN_MASK;
        end else if (enq) begin
            if (is_jump) begin
                pc_next = jump_target(pc4, imem_rdata);
            end else begin
                pc_next = pc4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (enq),
        .pop   (deq),
        .wdata (wr_entry),
        .rdata (head),
        .count (count)
    );

    assign id_instr = head_valid ? head.instr : '0;
    assign id_pc4   = head_valid ? head.pc4   : '0;
    assign fetch_pc = pc;
    assign q_count  = count;

endmodule
